fetch_ctrl: RTL

Fetch sequencer for the dual-issue front end. Owns the program counter, drives the word-pair instruction memory address every cycle, and captures the returned instruction pairs into a small fetch buffer. Hands pairs to decode over a valid/ready handshake and absorbs branch redirects from the back end.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int PAIR_STRIDE = 8;

  typedef enum logic [1:0] {
    RUN,
    FULL,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr1;
    logic [INSTR_W-1:0] instr2;
    logic               instr2_valid;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two FIFO of instruction pairs with flush and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_pair_t              push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_pair_t              head_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_pair_t   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, credit-based issue FSM, fetch buffer and perf counters.
// Perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        IMEM_BYTES = 2048,
  parameter logic [INSTR_W-1:0] RESET_PC   = '0,
  parameter int unsigned        FB_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [INSTR_W-1:0] imem_pc,
  input  logic [INSTR_W-1:0] imem_instr1,
  input  logic [INSTR_W-1:0] imem_instr2,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               pair_valid,
  input  logic               pair_ready,
  output logic [INSTR_W-1:0] pair_pc,
  output logic [INSTR_W-1:0] pair_instr1,
  output logic [INSTR_W-1:0] pair_instr2,
  output logic               pair_instr2_valid,
  output logic [INSTR_W-1:0] perf_stall_cycles,
  output logic [INSTR_W-1:0] perf_redirects
);

  localparam int CW = $clog2(FB_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [INSTR_W-1:0] ADDR_MASK = INSTR_W'(IMEM_BYTES - 1) & ~INSTR_W'(3);
  localparam logic [INSTR_W-1:0] LAST_WORD = INSTR_W'(IMEM_BYTES - 4);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] req_pc_q, req_pc_d;
  logic               req_i2v_q, req_i2v_d;
  logic               inflight_q, inflight_d;
  logic               issue, push, pop;
  logic [CW-1:0]      occ;
  logic [SW-1:0]      occ_next, credit_sum;
  fetch_pair_t        push_data, head;

  always_comb begin
    pop        = pair_valid & pair_ready;
    push       = inflight_q & ~redirect_valid;
    issue      = (state_q == RUN) & ~redirect_valid;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req_i2v_d  = req_i2v_q;
    inflight_d = issue;
    if (issue) begin
      req_pc_d  = pc_q;
      req_i2v_d = (pc_q != LAST_WORD);
      // A pair starting on the last word would straddle the top of memory.
      pc_d      = (pc_q == LAST_WORD) ? '0 : ((pc_q + INSTR_W'(PAIR_STRIDE)) & ADDR_MASK);
    end
    if (redirect_valid) pc_d = redirect_pc & ADDR_MASK;

    occ_next   = redirect_valid ? '0 : (SW'(occ) + SW'(push) - SW'(pop));
    credit_sum = occ_next + SW'(inflight_d);
    if (redirect_valid)                 state_d = FLUSH;
    else if (credit_sum < SW'(FB_DEPTH)) state_d = RUN;
    else                                state_d = FULL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      req_i2v_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      req_i2v_q  <= req_i2v_d;
      inflight_q <= inflight_d;
    end
  end

  assign push_data = '{pc: req_pc_q, instr1: imem_instr1, instr2: imem_instr2,
                       instr2_valid: req_i2v_q};

  fetch_fifo #(.DEPTH(FB_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .occupancy_o (occ)
  );

  // Head fields read as zero while the buffer is empty.
  assign imem_pc           = pc_q;
  assign pair_valid        = (occ != '0);
  assign pair_pc           = pair_valid ? head.pc     : '0;
  assign pair_instr1       = pair_valid ? head.instr1 : '0;
  assign pair_instr2       = pair_valid ? head.instr2 : '0;
  assign pair_instr2_valid = pair_valid & head.instr2_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [INSTR_W-1:0] stall_q, redir_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (pair_valid && !pair_ready) stall_q <= stall_q + 1'b1;
      if (redirect_valid)            redir_q <= redir_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_redirects    = redir_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif

endmodule
